cdb_arbiter: RTL and testbench

Arbitrates the single common data bus (CDB) among the execution-side producers (ALU, load/store buffer, branch unit) of the out-of-order core. Each producer hands a finished result (rename tag, destination register, value) through a valid/ready handshake into a private one-entry buffer. The arbiter grants one buffered result per cycle in round-robin order and drives the registered CDB broadcast consumed by the register file, reservation stations and ROB. A predictor flush discards everything in flight.

---
 rtl/cpu_defs.sv | 18 +
 rtl/rr_picker.sv | 33 +++
 rtl/cdb_arbiter.sv | 126 ++++++++++++
 tb/tb_cdb_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared core definitions: bus widths, producer indices and the CDB packet layout.
// Pure declarations; no timing or backpressure of its own.
package cpu_defs;
   localparam int NUM_SRC = 3;
   localparam int TAG_W   = 4;
   localparam int REG_W   = 5;
   localparam int DATA_W  = 32;

   localparam int SRC_ALU = 0;
   localparam int SRC_LSB = 1;
   localparam int SRC_BRU = 2;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [REG_W-1:0]  dest;
      logic [DATA_W-1:0] value;
   } cdb_pkt;
endpackage

// File: rtl/rr_picker.sv
// Rotating-priority one-hot picker: first set req bit from ptr upward with wrap.
// Purely combinational, zero latency; no backpressure (caller gates req).
module rr_picker #(
   parameter int N     = 3,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_vld
);

   int idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      idx       = 0;
      for (int i = 0; i < N; i++) begin
         // ptr is always < N, so one conditional subtract replaces a modulo
         idx = int'(ptr) + i;
         if (idx >= N) idx = idx - N;
         if (!grant_vld && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = IDX_W'(idx);
            grant_vld  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter over one-entry per-producer buffers; handshake to broadcast is 2 edges.
// src_ready drops only when a buffer is full and not being granted, on flush, or while rdy is low.
module cdb_arbiter #(
   parameter int NUM_SRC = cpu_defs::NUM_SRC,
   parameter int TAG_W   = cpu_defs::TAG_W,
   parameter int REG_W   = cpu_defs::REG_W,
   parameter int DATA_W  = cpu_defs::DATA_W,
   parameter int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rdy,
   input  logic                      flush,
   input  logic [NUM_SRC-1:0]        src_valid,
   output logic [NUM_SRC-1:0]        src_ready,
   input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
   input  logic [NUM_SRC*REG_W-1:0]  src_dest,
   input  logic [NUM_SRC*DATA_W-1:0] src_value,
   output logic                      cdb_valid,
   output logic [TAG_W-1:0]          cdb_tag,
   output logic [REG_W-1:0]          cdb_dest,
   output logic [DATA_W-1:0]         cdb_value,
   output logic [SRC_W-1:0]          cdb_src
);

   logic [NUM_SRC-1:0] buf_valid_q, buf_valid_d;
   logic [TAG_W-1:0]   buf_tag_q   [NUM_SRC];
   logic [TAG_W-1:0]   buf_tag_d   [NUM_SRC];
   logic [REG_W-1:0]   buf_dest_q  [NUM_SRC];
   logic [REG_W-1:0]   buf_dest_d  [NUM_SRC];
   logic [DATA_W-1:0]  buf_value_q [NUM_SRC];
   logic [DATA_W-1:0]  buf_value_d [NUM_SRC];
   logic [SRC_W-1:0]   ptr_q, ptr_d;

   logic               cdb_valid_q, cdb_valid_d;
   logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
   logic [REG_W-1:0]   cdb_dest_q, cdb_dest_d;
   logic [DATA_W-1:0]  cdb_value_q, cdb_value_d;
   logic [SRC_W-1:0]   cdb_src_q, cdb_src_d;

   logic [NUM_SRC-1:0] grant;
   logic [SRC_W-1:0]   grant_idx;
   logic               grant_vld;

   // Picker sees only registered state, so src_valid never feeds back into src_ready
   rr_picker #(.N(NUM_SRC), .IDX_W(SRC_W)) u_picker (
      .req       (buf_valid_q),
      .ptr       (ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_vld (grant_vld)
   );

   assign src_ready = {NUM_SRC{rdy & ~flush}} & (~buf_valid_q | grant);

   always_comb begin
      buf_valid_d = buf_valid_q;
      buf_tag_d   = buf_tag_q;
      buf_dest_d  = buf_dest_q;
      buf_value_d = buf_value_q;
      ptr_d       = ptr_q;
      cdb_valid_d = cdb_valid_q;
      cdb_tag_d   = cdb_tag_q;
      cdb_dest_d  = cdb_dest_q;
      cdb_value_d = cdb_value_q;
      cdb_src_d   = cdb_src_q;
      if (rdy && flush) begin
         buf_valid_d = '0;
         cdb_valid_d = 1'b0;
      end else if (rdy) begin
         cdb_valid_d = grant_vld;
         if (grant_vld) begin
            cdb_tag_d   = buf_tag_q[grant_idx];
            cdb_dest_d  = buf_dest_q[grant_idx];
            cdb_value_d = buf_value_q[grant_idx];
            cdb_src_d   = grant_idx;
            buf_valid_d = buf_valid_q & ~grant;
            ptr_d       = (int'(grant_idx) == NUM_SRC - 1) ? '0 : grant_idx + SRC_W'(1);
         end
         // Refill after the grant clear so a same-edge grant+capture keeps the new entry
         for (int i = 0; i < NUM_SRC; i++) begin
            if (src_valid[i] && src_ready[i]) begin
               buf_valid_d[i] = 1'b1;
               buf_tag_d[i]   = src_tag[i*TAG_W +: TAG_W];
               buf_dest_d[i]  = src_dest[i*REG_W +: REG_W];
               buf_value_d[i] = src_value[i*DATA_W +: DATA_W];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_valid_q <= '0;
         for (int i = 0; i < NUM_SRC; i++) begin
            buf_tag_q[i]   <= '0;
            buf_dest_q[i]  <= '0;
            buf_value_q[i] <= '0;
         end
         ptr_q       <= '0;
         cdb_valid_q <= 1'b0;
         cdb_tag_q   <= '0;
         cdb_dest_q  <= '0;
         cdb_value_q <= '0;
         cdb_src_q   <= '0;
      end else begin
         buf_valid_q <= buf_valid_d;
         buf_tag_q   <= buf_tag_d;
         buf_dest_q  <= buf_dest_d;
         buf_value_q <= buf_value_d;
         ptr_q       <= ptr_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_tag_q   <= cdb_tag_d;
         cdb_dest_q  <= cdb_dest_d;
         cdb_value_q <= cdb_value_d;
         cdb_src_q   <= cdb_src_d;
      end
   end

   assign cdb_valid = cdb_valid_q;
   assign cdb_tag   = cdb_tag_q;
   assign cdb_dest  = cdb_dest_q;
   assign cdb_value = cdb_value_q;
   assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: round-robin order, streaming, flush, rdy freeze, async reset.
module tb_cdb_arbiter;
   import cpu_defs::*;

   localparam int SW = $clog2(NUM_SRC);

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      rdy;
   logic                      flush;
   logic [NUM_SRC-1:0]        src_valid;
   logic [NUM_SRC-1:0]        src_ready;
   logic [NUM_SRC*TAG_W-1:0]  src_tag;
   logic [NUM_SRC*REG_W-1:0]  src_dest;
   logic [NUM_SRC*DATA_W-1:0] src_value;
   logic                      cdb_valid;
   logic [TAG_W-1:0]          cdb_tag;
   logic [REG_W-1:0]          cdb_dest;
   logic [DATA_W-1:0]         cdb_value;
   logic [SW-1:0]             cdb_src;

   int checks = 0;
   int errors = 0;

   cdb_arbiter #(.NUM_SRC(NUM_SRC), .TAG_W(TAG_W), .REG_W(REG_W), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .rdy       (rdy),
      .flush     (flush),
      .src_valid (src_valid),
      .src_ready (src_ready),
      .src_tag   (src_tag),
      .src_dest  (src_dest),
      .src_value (src_value),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_dest  (cdb_dest),
      .cdb_value (cdb_value),
      .cdb_src   (cdb_src)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_cdb(input string tag, input cdb_pkt p, input int src);
      chk({tag, ".valid"}, 64'(cdb_valid), 64'd1);
      chk({tag, ".tag"},   64'(cdb_tag),   64'(p.tag));
      chk({tag, ".dest"},  64'(cdb_dest),  64'(p.dest));
      chk({tag, ".value"}, 64'(cdb_value), 64'(p.value));
      chk({tag, ".src"},   64'(cdb_src),   64'(src));
   endtask

   task automatic offer(input int i, input cdb_pkt p);
      src_valid[i]                 = 1'b1;
      src_tag[i*TAG_W +: TAG_W]    = p.tag;
      src_dest[i*REG_W +: REG_W]   = p.dest;
      src_value[i*DATA_W +: DATA_W] = p.value;
   endtask

   task automatic idle();
      src_valid = '0;
   endtask

   cdb_pkt p0, p1, p2, q0, q2, g0, g1, g2, r0, r1, r2, s0;
   cdb_pkt ls [4];

   initial begin
      rst = 1'b1; rdy = 1'b1; flush = 1'b0;
      src_valid = '0; src_tag = '0; src_dest = '0; src_value = '0;
      #1;
      chk("reset.cdb_valid", 64'(cdb_valid), 64'd0);
      chk("reset.cdb_tag",   64'(cdb_tag),   64'd0);
      chk("reset.cdb_dest",  64'(cdb_dest),  64'd0);
      chk("reset.cdb_value", 64'(cdb_value), 64'd0);
      chk("reset.cdb_src",   64'(cdb_src),   64'd0);
      chk("reset.src_ready", 64'(src_ready), 64'b111);
      #1 rst = 1'b0;

      // Single ALU result, no contention
      p0 = '{tag: 4'd3, dest: 5'd5, value: 32'h1234};
      offer(SRC_ALU, p0);
      #1 chk("single.ready", 64'(src_ready), 64'b111);
      tick(); idle();
      chk("single.e1_valid", 64'(cdb_valid), 64'd0);
      tick();
      chk_cdb("single.e2", p0, SRC_ALU);
      tick();
      chk("single.e3_valid", 64'(cdb_valid), 64'd0);
      chk("single.e3_tag_hold", 64'(cdb_tag), 64'd3);

      // All three at once from ptr=0
      #2 rst = 1'b1;
      #1 rst = 1'b0;
      p0 = '{tag: 4'd8,  dest: 5'd1, value: 32'h100};
      p1 = '{tag: 4'd9,  dest: 5'd2, value: 32'h200};
      p2 = '{tag: 4'd10, dest: 5'd3, value: 32'h300};
      offer(0, p0); offer(1, p1); offer(2, p2);
      tick(); idle();
      chk("rr.cap_valid", 64'(cdb_valid), 64'd0);
      tick(); chk_cdb("rr.b0", p0, 0);
      tick(); chk_cdb("rr.b1", p1, 1);
      // ptr must now be back to 0: src0 beats src2
      q0 = '{tag: 4'd1, dest: 5'd0, value: 32'hAAAA};
      q2 = '{tag: 4'd2, dest: 5'd31, value: 32'hBBBB};
      tick(); chk_cdb("rr.b2", p2, 2);
      offer(0, q0); offer(2, q2);
      tick(); idle();
      chk("rr.ptr_cap_valid", 64'(cdb_valid), 64'd0);
      tick(); chk_cdb("rr.ptr0_first", q0, 0);
      tick(); chk_cdb("rr.ptr0_second", q2, 2);
      tick(); chk("rr.drain_valid", 64'(cdb_valid), 64'd0);

      // LSB streaming alone, one per cycle
      for (int k = 0; k < 4; k++) begin
         ls[k] = '{tag: TAG_W'(k + 1), dest: REG_W'(k + 4), value: DATA_W'(32'hA0 + k)};
      end
      for (int k = 0; k < 4; k++) begin
         offer(SRC_LSB, ls[k]);
         #1 chk($sformatf("stream.ready%0d", k), 64'(src_ready[SRC_LSB]), 64'd1);
         tick();
         if (k > 0) chk_cdb($sformatf("stream.cdb%0d", k - 1), ls[k-1], SRC_LSB);
      end
      idle();
      tick(); chk_cdb("stream.cdb3", ls[3], SRC_LSB);
      tick(); chk("stream.done_valid", 64'(cdb_valid), 64'd0);

      // Flush with two buffered and a third offered
      offer(0, '{tag: 4'd5, dest: 5'd10, value: 32'h55});
      offer(1, '{tag: 4'd6, dest: 5'd11, value: 32'h66});
      tick(); idle();
      offer(2, '{tag: 4'd7, dest: 5'd12, value: 32'h77});
      flush = 1'b1;
      #1 chk("flush.ready", 64'(src_ready), 64'b000);
      tick(); flush = 1'b0; idle();
      chk("flush.e0_valid", 64'(cdb_valid), 64'd0);
      tick(); chk("flush.e1_valid", 64'(cdb_valid), 64'd0);
      tick(); chk("flush.e2_valid", 64'(cdb_valid), 64'd0);
      chk("flush.ready_after", 64'(src_ready), 64'b111);

      // rdy low freeze with tag 7 on the bus (ptr=2 here)
      g0 = '{tag: 4'd11, dest: 5'd13, value: 32'hB0B};
      g1 = '{tag: 4'd12, dest: 5'd14, value: 32'hC0C};
      g2 = '{tag: 4'd7,  dest: 5'd7,  value: 32'h777};
      offer(0, g0); offer(1, g1); offer(2, g2);
      tick(); idle();
      chk("frz.cap_valid", 64'(cdb_valid), 64'd0);
      tick(); chk_cdb("frz.pre", g2, 2);
      rdy = 1'b0;
      offer(2, '{tag: 4'd15, dest: 5'd15, value: 32'hDEAD});
      #1 chk("frz.ready", 64'(src_ready), 64'b000);
      for (int k = 0; k < 3; k++) begin
         flush = (k == 1);
         tick();
         chk_cdb($sformatf("frz.hold%0d", k), g2, 2);
      end
      rdy = 1'b1; flush = 1'b0; idle();
      tick(); chk_cdb("frz.post0", g0, 0);
      tick(); chk_cdb("frz.post1", g1, 1);
      tick(); chk("frz.no_dup", 64'(cdb_valid), 64'd0);

      // Async reset mid-cycle with buffers pending (ptr=2 here)
      r0 = '{tag: 4'd1, dest: 5'd1, value: 32'h11};
      r1 = '{tag: 4'd2, dest: 5'd2, value: 32'h22};
      r2 = '{tag: 4'd3, dest: 5'd3, value: 32'h33};
      offer(0, r0); offer(1, r1); offer(2, r2);
      tick(); idle();
      tick(); chk_cdb("arst.pre", r2, 2);
      chk("arst.pre_ready", 64'(src_ready), 64'b101);
      #2 rst = 1'b1;
      #1;
      chk("arst.valid", 64'(cdb_valid), 64'd0);
      chk("arst.ready", 64'(src_ready), 64'b111);
      chk("arst.tag",   64'(cdb_tag),   64'd0);
      chk("arst.src",   64'(cdb_src),   64'd0);
      #1 rst = 1'b0;
      s0 = '{tag: 4'd15, dest: 5'd0, value: 32'hFFFF_0001};
      offer(SRC_ALU, s0);
      tick(); idle();
      chk("arst.after_valid", 64'(cdb_valid), 64'd0);
      tick(); chk_cdb("arst.first", s0, SRC_ALU);
      tick(); chk("arst.end_valid", 64'(cdb_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
